sun_apb_requester: RTL
======================

Name: sun_apb_requester

Overview:
- APB3 requester (master) that drives the sun-sensor APB completer through one full acquisition.
- Sequence: program control, threshold, xmax and ymax; stream xmax*ymax pixel bytes from an upstream valid/ready source; poll status until the result is ready; read centroid h and k; present them to the navigation core.
- Sits between the pixel front-end and the sun-sensor register block.

Parameters:
- POLL_LIMIT, 255, maximum status reads before timeout (1..65535)
- POLL_GAP, 4, idle cycles between consecutive status reads (>=1)

Ports:
- pclk  in  1  system clock, all logic on rising edge
- presetn  in  1  synchronous active-low reset
- start  in  1  one-cycle request to begin a sequence; ignored while busy
- threshold  in  8  value written to THRESH, sampled at accepted start
- xmax  in  8  value written to XMAX, sampled at accepted start
- ymax  in  8  value written to YMAX, sampled at accepted start
- pix_data  in  8  pixel byte
- pix_valid  in  1  pixel byte valid
- pix_ready  out  1  requester accepts pix_data this cycle
- psel  out  1  APB select
- penable  out  1  APB enable
- pwrite  out  1  APB direction, 1 = write
- paddr  out  32  APB address
- pwdata  out  32  APB write data
- prdata  in  32  APB read data
- pready  in  1  APB completer ready
- busy  out  1  sequence in progress
- done  out  1  one-cycle pulse at sequence end
- h_out  out  32  centroid x, from H register
- k_out  out  32  centroid y, from K register
- timeout_err  out  1  sticky; poll limit reached; cleared by the next accepted start

Behaviour:
- Register map: CTRL 0x0, THRESH 0x1, XMAX 0x2, YMAX 0x3, DATA 0x4, STATUS 0x5, H 0x8, K 0x9. STATUS bit0 = result ready.
- Write data is zero-extended to 32 bits. The CTRL write value is 0x00000001.
- Reset: all outputs 0, FSM in IDLE, pixel counter 0. Reset mid-transfer drops psel/penable on the same edge; no completion is generated.
- APB transfer timing:
  - SETUP cycle: psel=1, penable=0, with paddr/pwrite/pwdata valid.
  - ACCESS: psel=1, penable=1, held until pready=1; addr/data stable throughout.
  - After completion, one IDLE cycle with psel=0, penable=0.
  - Minimum 3 cycles per transfer; each wait state adds 1.
- Read data is captured on the ACCESS cycle where pready=1.
- FSM states: IDLE, CFG_CTRL, CFG_THR, CFG_XMAX, CFG_YMAX, PIX_WAIT, PIX_WR, POLL_RD, POLL_GAP, RD_H, RD_K, FIN.
  - IDLE -> CFG_CTRL on start. busy rises the cycle after start.
  - The four CFG states each perform one write in order.
  - PIX_WAIT: pix_ready=1 only in this state. A handshake (pix_valid & pix_ready) latches the byte and moves to PIX_WR, which writes it to DATA. pix_ready is never asserted during a transfer.
  - Pixel count is a 16-bit product xmax*ymax. After the last DATA write go to POLL_RD. Count 0 skips PIX states entirely.
  - POLL_RD: read STATUS. If bit0=1, go to RD_H. Otherwise, if the read count equals POLL_LIMIT, set timeout_err and go to FIN. Otherwise go to POLL_GAP, wait POLL_GAP cycles, and return to POLL_RD.
  - RD_H, then RD_K, each latch prdata into h_out/k_out.
  - FIN: done=1 for one cycle, busy=0 on the next cycle, return to IDLE.
- h_out/k_out hold their last value until overwritten. On timeout they are unchanged.
- start coincident with FIN is ignored.

Optional Feature:
- Macro SUN_APB_PSLVERR_EN.
- With it defined: input pslverr (1 bit) and sticky output slv_err are added. pslverr=1 on a completing ACCESS aborts the sequence, sets slv_err, and goes to FIN, which pulses done. slv_err is cleared by the next accepted start.
- Without it: neither port exists and the completer never signals errors.

Decomposition:
- Package sun_apb_pkg: register address constants, STATUS_READY_BIT, CTRL_ENABLE value, FSM state enum.
- Sub-module apb_xfer: a single-transfer engine (req/addr/wdata/write in; ack/rdata out; SETUP/ACCESS/IDLE timing).
- The sequencer FSM lives in the top module and issues req to apb_xfer.

Test Plan:
- Zero-wait completer; start with threshold=0x0F, xmax=2, ymax=2, four pixels 0x10; STATUS bit0 set after 4th DATA write; H=0x1, K=0x1.
  -> Writes 0x1@0, 0x0F@1, 0x02@2, 0x02@3, 4x 0x10@4; one STATUS read; h_out=1, k_out=1; done pulses once.
- Same sequence with pready delayed 2 cycles on every transfer.
  -> Each ACCESS lasts 3 cycles; addr/data stable; same results.
- pix_valid gaps of 5 cycles between pixels.
  -> psel stays 0 while waiting; exactly 4 DATA writes.
- STATUS never ready, POLL_LIMIT=3, POLL_GAP=4.
  -> 3 STATUS reads spaced by 4 idle cycles; timeout_err=1; done pulses; h_out/k_out unchanged.
- xmax=0.
  -> No DATA writes; polling begins right after the YMAX write.
- presetn low during the XMAX ACCESS, then start again.
  -> Outputs zero after the reset edge; the new sequence restarts at CTRL.

Source files
------------

// File: rtl/sun_apb_pkg.sv
// Register map, constants and state encodings shared by the
// sun-sensor APB requester and its transfer engine.
package sun_apb_pkg;

  localparam logic [31:0] ADDR_CTRL   = 32'h0;
  localparam logic [31:0] ADDR_THRESH = 32'h1;
  localparam logic [31:0] ADDR_XMAX   = 32'h2;
  localparam logic [31:0] ADDR_YMAX   = 32'h3;
  localparam logic [31:0] ADDR_DATA   = 32'h4;
  localparam logic [31:0] ADDR_STATUS = 32'h5;
  localparam logic [31:0] ADDR_H      = 32'h8;
  localparam logic [31:0] ADDR_K      = 32'h9;

  localparam int          STATUS_READY_BIT = 0;
  localparam logic [31:0] CTRL_ENABLE      = 32'h1;

  typedef enum logic [3:0] {
    S_IDLE,
    S_CFG_CTRL,
    S_CFG_THR,
    S_CFG_XMAX,
    S_CFG_YMAX,
    S_PIX_WAIT,
    S_PIX_WR,
    S_POLL_RD,
    S_POLL_GAP,
    S_RD_H,
    S_RD_K,
    S_FIN
  } state_e;

  typedef enum logic [1:0] {
    X_IDLE,
    X_SETUP,
    X_ACCESS
  } xfer_e;

endpackage

// File: rtl/sun_apb_requester_xfer.sv
// Single APB3 transfer engine: accepts a request while idle, then runs
// SETUP and ACCESS; the accepting cycle is the bus-idle cycle.
module apb_xfer
  import sun_apb_pkg::*;
(
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        req_i,
  input  logic        write_i,
  input  logic [31:0] addr_i,
  input  logic [31:0] wdata_i,
  output logic        ack_o,
  output logic [31:0] rdata_o,
`ifdef SUN_APB_PSLVERR_EN
  input  logic        pslverr_i,
  output logic        err_o,
`endif
  output logic        psel_o,
  output logic        penable_o,
  output logic        pwrite_o,
  output logic [31:0] paddr_o,
  output logic [31:0] pwdata_o,
  input  logic [31:0] prdata_i,
  input  logic        pready_i
);

  xfer_e       xs_q, xs_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic        write_q, write_d;

  always_comb begin
    xs_d    = xs_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    write_d = write_q;
    unique case (xs_q)
      X_IDLE: if (req_i) begin
        xs_d    = X_SETUP;
        addr_d  = addr_i;
        wdata_d = wdata_i;
        write_d = write_i;
      end
      X_SETUP:  xs_d = X_ACCESS;
      X_ACCESS: if (pready_i) xs_d = X_IDLE;
      default:  xs_d = X_IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      xs_q    <= X_IDLE;
      addr_q  <= '0;
      wdata_q <= '0;
      write_q <= 1'b0;
    end else begin
      xs_q    <= xs_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      write_q <= write_d;
    end
  end

  assign ack_o     = (xs_q == X_ACCESS) && pready_i;
  assign rdata_o   = prdata_i;
  assign psel_o    = (xs_q != X_IDLE);
  assign penable_o = (xs_q == X_ACCESS);
  assign pwrite_o  = write_q;
  assign paddr_o   = addr_q;
  assign pwdata_o  = wdata_q;
`ifdef SUN_APB_PSLVERR_EN
  assign err_o     = ack_o && pslverr_i;
`endif

endmodule

// File: rtl/sun_apb_requester.sv
// Sun-sensor APB requester: configure, stream pixels, poll, read centroid.
// Optional completer error abort enabled by SUN_APB_PSLVERR_EN.
module sun_apb_requester
  import sun_apb_pkg::*;
#(
  parameter int unsigned POLL_LIMIT = 255,
  parameter int unsigned POLL_GAP   = 4
) (
  input  logic        pclk,
  input  logic        presetn,
  input  logic        start,
  input  logic [7:0]  threshold,
  input  logic [7:0]  xmax,
  input  logic [7:0]  ymax,
  input  logic [7:0]  pix_data,
  input  logic        pix_valid,
  output logic        pix_ready,
  output logic        psel,
  output logic        penable,
  output logic        pwrite,
  output logic [31:0] paddr,
  output logic [31:0] pwdata,
  input  logic [31:0] prdata,
  input  logic        pready,
`ifdef SUN_APB_PSLVERR_EN
  input  logic        pslverr,
  output logic        slv_err,
`endif
  output logic        busy,
  output logic        done,
  output logic [31:0] h_out,
  output logic [31:0] k_out,
  output logic        timeout_err
);

  localparam logic [15:0] LIM  = 16'(POLL_LIMIT);
  localparam logic [15:0] GAP0 = 16'(POLL_GAP - 1);

  state_e      state_q, state_d;
  logic [7:0]  thr_q, thr_d, xm_q, xm_d, ym_q, ym_d, pix_q, pix_d;
  logic [15:0] total_q, total_d, cnt_q, cnt_d;
  logic [15:0] poll_q, poll_d, gap_q, gap_d;
  logic [31:0] h_q, h_d, k_q, k_d;
  logic        tmo_q, tmo_d;
  logic        req, wr, ack;
  logic [31:0] addr, wdata, rdata;
`ifdef SUN_APB_PSLVERR_EN
  logic        slv_q, slv_d, err;
`endif

  apb_xfer u_xfer (
    .clk_i     (pclk),
    .rst_ni    (presetn),
    .req_i     (req),
    .write_i   (wr),
    .addr_i    (addr),
    .wdata_i   (wdata),
    .ack_o     (ack),
    .rdata_o   (rdata),
`ifdef SUN_APB_PSLVERR_EN
    .pslverr_i (pslverr),
    .err_o     (err),
`endif
    .psel_o    (psel),
    .penable_o (penable),
    .pwrite_o  (pwrite),
    .paddr_o   (paddr),
    .pwdata_o  (pwdata),
    .prdata_i  (prdata),
    .pready_i  (pready)
  );

  always_comb begin
    state_d = state_q;
    thr_d   = thr_q;
    xm_d    = xm_q;
    ym_d    = ym_q;
    pix_d   = pix_q;
    total_d = total_q;
    cnt_d   = cnt_q;
    poll_d  = poll_q;
    gap_d   = gap_q;
    h_d     = h_q;
    k_d     = k_q;
    tmo_d   = tmo_q;
`ifdef SUN_APB_PSLVERR_EN
    slv_d   = slv_q;
`endif
    req     = 1'b0;
    wr      = 1'b0;
    addr    = ADDR_CTRL;
    wdata   = '0;
    unique case (state_q)
      S_IDLE: if (start) begin
        state_d = S_CFG_CTRL;
        thr_d   = threshold;
        xm_d    = xmax;
        ym_d    = ymax;
        total_d = 16'(xmax) * 16'(ymax);
        cnt_d   = '0;
        poll_d  = '0;
        tmo_d   = 1'b0;
`ifdef SUN_APB_PSLVERR_EN
        slv_d   = 1'b0;
`endif
      end
      S_CFG_CTRL: begin
        req = 1'b1; wr = 1'b1;
        addr = ADDR_CTRL; wdata = CTRL_ENABLE;
        if (ack) state_d = S_CFG_THR;
      end
      S_CFG_THR: begin
        req = 1'b1; wr = 1'b1;
        addr = ADDR_THRESH; wdata = {24'h0, thr_q};
        if (ack) state_d = S_CFG_XMAX;
      end
      S_CFG_XMAX: begin
        req = 1'b1; wr = 1'b1;
        addr = ADDR_XMAX; wdata = {24'h0, xm_q};
        if (ack) state_d = S_CFG_YMAX;
      end
      S_CFG_YMAX: begin
        req = 1'b1; wr = 1'b1;
        addr = ADDR_YMAX; wdata = {24'h0, ym_q};
        if (ack) state_d = (total_q == '0) ? S_POLL_RD : S_PIX_WAIT;
      end
      S_PIX_WAIT: if (pix_valid) begin
        pix_d   = pix_data;
        state_d = S_PIX_WR;
      end
      S_PIX_WR: begin
        req = 1'b1; wr = 1'b1;
        addr = ADDR_DATA; wdata = {24'h0, pix_q};
        if (ack) begin
          cnt_d   = cnt_q + 16'd1;
          state_d = (cnt_d == total_q) ? S_POLL_RD : S_PIX_WAIT;
        end
      end
      S_POLL_RD: begin
        req = 1'b1; addr = ADDR_STATUS;
        if (ack) begin
          poll_d = poll_q + 16'd1;
          if (rdata[STATUS_READY_BIT]) begin
            state_d = S_RD_H;
          end else if (poll_d == LIM) begin
            tmo_d   = 1'b1;
            state_d = S_FIN;
          end else begin
            // the engine's accept cycle supplies the last gap cycle
            gap_d   = GAP0;
            state_d = (POLL_GAP > 1) ? S_POLL_GAP : S_POLL_RD;
          end
        end
      end
      S_POLL_GAP: begin
        if (gap_q <= 16'd1) state_d = S_POLL_RD;
        else gap_d = gap_q - 16'd1;
      end
      S_RD_H: begin
        req = 1'b1; addr = ADDR_H;
        if (ack) begin
          h_d     = rdata;
          state_d = S_RD_K;
        end
      end
      S_RD_K: begin
        req = 1'b1; addr = ADDR_K;
        if (ack) begin
          k_d     = rdata;
          state_d = S_FIN;
        end
      end
      S_FIN:   state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
`ifdef SUN_APB_PSLVERR_EN
    if (err) begin
      state_d = S_FIN;
      slv_d   = 1'b1;
      h_d     = h_q;
      k_d     = k_q;
      tmo_d   = tmo_q;
    end
`endif
  end

  always_ff @(posedge pclk) begin
    if (!presetn) begin
      state_q <= S_IDLE;
      thr_q   <= '0;
      xm_q    <= '0;
      ym_q    <= '0;
      pix_q   <= '0;
      total_q <= '0;
      cnt_q   <= '0;
      poll_q  <= '0;
      gap_q   <= '0;
      h_q     <= '0;
      k_q     <= '0;
      tmo_q   <= 1'b0;
`ifdef SUN_APB_PSLVERR_EN
      slv_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      thr_q   <= thr_d;
      xm_q    <= xm_d;
      ym_q    <= ym_d;
      pix_q   <= pix_d;
      total_q <= total_d;
      cnt_q   <= cnt_d;
      poll_q  <= poll_d;
      gap_q   <= gap_d;
      h_q     <= h_d;
      k_q     <= k_d;
      tmo_q   <= tmo_d;
`ifdef SUN_APB_PSLVERR_EN
      slv_q   <= slv_d;
`endif
    end
  end

  assign pix_ready   = (state_q == S_PIX_WAIT);
  assign busy        = (state_q != S_IDLE);
  assign done        = (state_q == S_FIN);
  assign h_out       = h_q;
  assign k_out       = k_q;
  assign timeout_err = tmo_q;
`ifdef SUN_APB_PSLVERR_EN
  assign slv_err     = slv_q;
`endif

endmodule
